// File: rtl/da_fir_serial_if.sv
// -----------------------------------------------------------------------------
// da_fir_serial_if
//   Sample-in / result-out bundle of the bit-serial DA FIR filter.
//
//   Parameters
//     DIN_WIDTH   signed input sample width
//     DOUT_WIDTH  signed filter output width
//
//   Signals
//     flush      source -> filter  clear delay line, abort computation
//     din        source -> filter  signed input sample
//     in_valid   source -> filter  din valid
//     in_ready   filter -> source  filter accepts din this cycle
//     dout       filter -> sink    signed filter output
//     out_valid  filter -> sink    one-clock pulse, dout valid
//
//   Modports
//     master  sample source / result sink side
//     slave   filter side
// -----------------------------------------------------------------------------
interface da_fir_serial_if #(
  parameter int DIN_WIDTH  = 12,
  parameter int DOUT_WIDTH = 26
);
  logic                         flush;
  logic signed [DIN_WIDTH-1:0]  din;
  logic                         in_valid;
  logic                         in_ready;
  logic signed [DOUT_WIDTH-1:0] dout;
  logic                         out_valid;

  modport master (
    output flush, din, in_valid,
    input  in_ready, dout, out_valid
  );

  modport slave (
    input  flush, din, in_valid,
    output in_ready, dout, out_valid
  );
endinterface

// File: rtl/da_fir_serial.sv
// -----------------------------------------------------------------------------
// da_fir_serial
//   Bit-serial distributed-arithmetic FIR filter. Keeps a TAPS-deep sample
//   delay line and a 2^TAPS-entry partial-sum LUT built from COEFFS at
//   elaboration. Each accepted sample produces one full-precision output
//   y[n] = sum b[k]*x[n-k] after DIN_WIDTH serial clocks (MSB first).
//
//   Parameters
//     TAPS         number of taps (2..8)
//     DIN_WIDTH    signed input width, also serial cycles per sample
//     COEFF_WIDTH  signed coefficient width
//     COEFFS       packed coefficients, slice k = b[k] multiplies x[n-k]
//
//   Ports
//     clk  in     rising-edge clock
//     rst  in     synchronous active-high reset (overrides flush)
//     bus  slave  flush / din / in_valid / in_ready / dout / out_valid
// -----------------------------------------------------------------------------
module da_fir_serial #(
  parameter int                         TAPS        = 4,
  parameter int                         DIN_WIDTH   = 12,
  parameter int                         COEFF_WIDTH = 12,
  parameter logic [TAPS*COEFF_WIDTH-1:0] COEFFS     = {12'd510, 12'd341, 12'd132, 12'd41}
) (
  input  logic           clk,
  input  logic           rst,
  da_fir_serial_if.slave bus
);

  localparam int DOUT_WIDTH = DIN_WIDTH + COEFF_WIDTH + $clog2(TAPS);
  localparam int LUT_SIZE   = 1 << TAPS;
  localparam int CNT_W      = $clog2(DIN_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Sum of the coefficients selected by the set bits of address a.
  function automatic logic signed [DOUT_WIDTH-1:0] lut_entry(input int a);
    logic signed [DOUT_WIDTH-1:0]  sum;
    logic signed [COEFF_WIDTH-1:0] coef;
    sum = '0;
    for (int k = 0; k < TAPS; k++) begin
      coef = COEFFS[k*COEFF_WIDTH +: COEFF_WIDTH];
      if (a[k]) sum = sum + coef;
    end
    return sum;
  endfunction

  // Partial-sum table, fixed at elaboration.
  logic signed [DOUT_WIDTH-1:0] lut [LUT_SIZE];
  for (genvar a = 0; a < LUT_SIZE; a++) begin : g_lut
    localparam logic signed [DOUT_WIDTH-1:0] ENTRY = lut_entry(a);
    assign lut[a] = ENTRY;
  end

  state_t                       state_q, state_d;
  logic [DIN_WIDTH-1:0]         x_q [TAPS];
  logic [CNT_W-1:0]             cnt_q;
  logic signed [DOUT_WIDTH-1:0] acc_q, acc_d;
  logic signed [DOUT_WIDTH-1:0] dout_q;

  logic [TAPS-1:0]              addr;
  logic signed [DOUT_WIDTH-1:0] lut_sel;
  logic                         last_bit;
  logic                         accept;
  logic                         in_ready;
  logic                         out_valid;

  assign last_bit = (cnt_q == CNT_W'(DIN_WIDTH - 1));

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking (<=) so every register samples the
  // pre-edge values of the others; blocking here would create order-dependent
  // simulation that does not match the synthesized flops.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and handshake outputs
  // ---------------------------------------------------------------------------
  // NOTE: every output of this block is given a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          accept  = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (last_bit) state_d = DONE;
      end
      DONE: begin
        in_ready  = 1'b1;
        out_valid = 1'b1;
        accept    = bus.in_valid;
        state_d   = bus.in_valid ? BUSY : IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Flush wins over everything except rst: no accept, no result this cycle.
    if (bus.flush) begin
      state_d   = IDLE;
      accept    = 1'b0;
      in_ready  = 1'b0;
      out_valid = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Bit-plane address and accumulator update
  // ---------------------------------------------------------------------------
  always_comb begin
    addr = '0;
    for (int k = 0; k < TAPS; k++) addr[k] = x_q[k][DIN_WIDTH-1];
    lut_sel = lut[addr];
    // The sign bit-plane carries negative weight in two's complement.
    if (cnt_q == '0) acc_d = -lut_sel;
    else             acc_d = (acc_q <<< 1) + lut_sel;
  end

  // ---------------------------------------------------------------------------
  // Datapath
  //   The delay line doubles as the serial shifter: each tap rotates left
  //   once per BUSY clock, so after DIN_WIDTH rotations every sample is back
  //   in its original alignment, ready for the next shift-in.
  // ---------------------------------------------------------------------------
  // NOTE: the delay line is a small register array whose contents feed every
  // future output, so it is reset explicitly; a RAM-style array would not be.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < TAPS; k++) x_q[k] <= '0;
      acc_q  <= '0;
      dout_q <= '0;
      cnt_q  <= '0;
    end else if (bus.flush) begin
      for (int k = 0; k < TAPS; k++) x_q[k] <= '0;
      acc_q <= '0;
      cnt_q <= '0;
    end else if (accept) begin
      x_q[0] <= bus.din;
      for (int k = 1; k < TAPS; k++) x_q[k] <= x_q[k-1];
      cnt_q <= '0;
    end else if (state_q == BUSY) begin
      for (int k = 0; k < TAPS; k++) x_q[k] <= {x_q[k][DIN_WIDTH-2:0], x_q[k][DIN_WIDTH-1]};
      acc_q <= acc_d;
      cnt_q <= cnt_q + CNT_W'(1);
      // Result is registered as the last bit-plane lands, so dout is already
      // valid during the single DONE cycle.
      if (last_bit) dout_q <= acc_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.dout      = dout_q;

endmodule

// File: tb/tb_da_fir_serial.sv
module tb_da_fir_serial;

  localparam int DW  = 12;
  localparam int OW  = 26;
  localparam int LAT = 13;   // accept-to-out_valid distance and sample period

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  da_fir_serial_if #(.DIN_WIDTH(DW), .DOUT_WIDTH(OW)) bus ();

  da_fir_serial dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state: taps b[0..3] and sample history x[n-k].
  int     coef [4] = '{41, 132, 341, 510};
  longint hist [4] = '{0, 0, 0, 0};
  bit     active   = 1'b0;
  bit     accepted = 1'b0;
  int     cyc      = 0;
  int     acc_c    = 0;
  logic signed [OW-1:0] exp_dout  = '0;
  logic signed [OW-1:0] pend_dout = '0;
  logic signed [OW-1:0] seen_dout = '0;
  int     dut_accepts = 0;
  int     dut_ovs     = 0;
  int     ov_mark     = 0;

  int imp_exp  [5] = '{41, 132, 341, 510, 0};
  int step_exp [4] = '{41, 173, 514, 1024};
  int sign_exp [4] = '{-41, -132, -341, -510};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic longint fir_out();
    longint s = 0;
    for (int k = 0; k < 4; k++) s += longint'(coef[k]) * hist[k];
    return s;
  endfunction

  // One clock: drive inputs after the falling edge, compare outputs against
  // the timing/arithmetic model, then advance the model.
  task automatic cycle(input logic v, input logic signed [DW-1:0] d, input logic fl, input logic r);
    logic exp_ready, exp_valid;
    @(negedge clk);
    bus.in_valid = v;
    bus.din      = d;
    bus.flush    = fl;
    rst          = r;
    #1;
    cyc++;
    exp_valid = active && !fl && (cyc - acc_c == LAT);
    exp_ready = !fl && (!active || (cyc - acc_c >= LAT));
    if (exp_valid) exp_dout = pend_dout;
    chk("out_valid", bus.out_valid, exp_valid);
    chk("in_ready", bus.in_ready, exp_ready);
    chk("dout", bus.dout, exp_dout);
    if (bus.out_valid) begin
      seen_dout = bus.dout;
      dut_ovs++;
    end
    if (v && bus.in_ready && !r) dut_accepts++;
    accepted = 1'b0;
    if (r) begin
      active   = 1'b0;
      hist     = '{0, 0, 0, 0};
      exp_dout = '0;
    end else if (fl) begin
      active = 1'b0;
      hist   = '{0, 0, 0, 0};
    end else begin
      if (exp_valid) active = 1'b0;
      if (v && exp_ready) begin
        for (int k = 3; k > 0; k--) hist[k] = hist[k-1];
        hist[0]   = longint'(d);
        pend_dout = OW'(fir_out());
        active    = 1'b1;
        acc_c     = cyc;
        accepted  = 1'b1;
      end
    end
  endtask

  // Present a sample until accepted (bounded), then idle through its result.
  task automatic send(input logic signed [DW-1:0] d);
    int n;
    n = 0;
    seen_dout = 'x;
    accepted  = 1'b0;
    while (!accepted && n < 40) begin
      cycle(1'b1, d, 1'b0, 1'b0);
      n++;
    end
    repeat (LAT) cycle(1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    logic fl;
    bus.in_valid = 1'b0;
    bus.din      = '0;
    bus.flush    = 1'b0;
    rst          = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_dout", bus.dout, 0);
    chk("reset_out_valid", bus.out_valid, 1'b0);
    chk("reset_in_ready", bus.in_ready, 1'b1);

    // Impulse response
    for (int i = 0; i < 5; i++) begin
      send((i == 0) ? 12'sd1 : 12'sd0);
      chk($sformatf("impulse_%0d", i), seen_dout, imp_exp[i]);
    end

    // Step response
    cycle(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      send(12'sd1);
      chk($sformatf("step_%0d", i), seen_dout, step_exp[i]);
    end

    // Negative impulse
    cycle(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      send((i == 0) ? -12'sd1 : 12'sd0);
      chk($sformatf("neg_impulse_%0d", i), seen_dout, sign_exp[i]);
    end

    // Most negative input on all taps
    cycle(1'b0, '0, 1'b1, 1'b0);
    repeat (4) send(-12'sd2048);
    chk("min_input_full", seen_dout, -2097152);

    // Continuous in_valid: one accept every LAT clocks
    cycle(1'b0, '0, 1'b1, 1'b0);
    dut_accepts = 0;
    dut_ovs     = 0;
    repeat (6 * LAT + 1) cycle(1'b1, DW'($urandom), 1'b0, 1'b0);
    repeat (LAT) cycle(1'b0, '0, 1'b0, 1'b0);
    chk("stream_accepts", dut_accepts, 7);
    chk("stream_out_valids", dut_ovs, 7);

    // Flush mid-BUSY aborts the result and clears history
    cycle(1'b0, '0, 1'b1, 1'b0);
    send(12'sd1);
    send(12'sd0);
    send(12'sd0);
    cycle(1'b1, '0, 1'b0, 1'b0);
    repeat (5) cycle(1'b0, '0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    ov_mark = dut_ovs;
    repeat (20) cycle(1'b0, '0, 1'b0, 1'b0);
    chk("flush_no_out_valid", dut_ovs, ov_mark);
    send(12'sd1);
    chk("flush_then_impulse", seen_dout, 41);

    // Random traffic; in_valid during BUSY must be ignored
    for (int i = 0; i < 400; i++) begin
      fl = ($urandom_range(0, 59) == 0) && !(active && (cyc + 1 - acc_c == LAT));
      cycle(($urandom_range(0, 3) != 0), DW'($urandom), fl, 1'b0);
    end
    repeat (LAT + 1) cycle(1'b0, '0, 1'b0, 1'b0);

    // Reset mid-BUSY discards the computation
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b1, 12'sd100, 1'b0, 1'b0);
    repeat (5) cycle(1'b0, '0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b1);
    ov_mark = dut_ovs;
    cycle(1'b0, '0, 1'b0, 1'b0);
    chk("rst_mid_dout", bus.dout, 0);
    chk("rst_mid_out_valid", bus.out_valid, 1'b0);
    chk("rst_mid_in_ready", bus.in_ready, 1'b1);
    repeat (20) cycle(1'b0, '0, 1'b0, 1'b0);
    chk("rst_no_stale_output", dut_ovs, ov_mark);
    send(12'sd1);
    chk("rst_then_impulse", seen_dout, 41);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
